// File: rtl/dm_lsu_initiator_if.sv
// Bundle of the MEM-stage request/response and DM port signals for dm_lsu_initiator.
// The master side is the pipeline plus the DM array; the slave side is the initiator.
interface dm_lsu_initiator_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [2:0]  sb_count;
   logic        dm_MemWr;
   logic        dm_MemWrComp;
   logic [31:0] dm_in;
   logic [31:0] dm_addr;
   logic [31:0] dm_addr_c;
   logic [31:0] dm_out;

   modport master (
      output req_valid, req_op, req_addr, req_wdata, dm_out,
      input  req_ready, rsp_valid, rsp_rdata, sb_count,
      input  dm_MemWr, dm_MemWrComp, dm_in, dm_addr, dm_addr_c
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, dm_out,
      output req_ready, rsp_valid, rsp_rdata, sb_count,
      output dm_MemWr, dm_MemWrComp, dm_in, dm_addr, dm_addr_c
   );
endinterface

// File: rtl/dm_lsu_initiator.sv
// Load/store initiator: buffers stores in a FIFO drained lazily to DM, forwards to loads, handles fence.
// Define DM_LSU_MIRROR_EN to mirror every drain to the word index with its top bit flipped.
module dm_lsu_initiator #(
   parameter int unsigned SB_DEPTH = 4,
   parameter int unsigned IDX_LSB  = 2,
   parameter int unsigned IDX_W    = 4
) (
   input logic             clk,
   input logic             reset,
   dm_lsu_initiator_if.slave bus
);
   localparam int unsigned PtrW = $clog2(SB_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [31:0] IdxMask = ((32'd1 << IDX_W) - 32'd1) << IDX_LSB;
`ifdef DM_LSU_MIRROR_EN
   localparam logic [31:0] MirrorBit = 32'd1 << (IDX_LSB + IDX_W - 1);
`endif

   localparam logic [1:0] OpLoad  = 2'b00;
   localparam logic [1:0] OpStore = 2'b01;
   localparam logic [1:0] OpFence = 2'b10;

   typedef enum logic [0:0] {StRun, StDrain} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
   logic [31:0]     addr_q [SB_DEPTH];
   logic [31:0]     addr_d [SB_DEPTH];
   logic [31:0]     data_q [SB_DEPTH];
   logic [31:0]     data_d [SB_DEPTH];
   logic            rsp_valid_q, rsp_valid_d;
   logic [31:0]     rsp_rdata_q, rsp_rdata_d;

   logic            full, accept, is_load, push, drain;
   logic [PtrW-1:0] slot;
   logic [31:0]     fwd_data;

   // Addresses alias on the DM word index only; upper address bits are ignored.
   function automatic logic idx_hit(logic [31:0] a, logic [31:0] b);
`ifdef DM_LSU_MIRROR_EN
      return (((a ^ b) & IdxMask) == '0) || (((a ^ b ^ MirrorBit) & IdxMask) == '0);
`else
      return ((a ^ b) & IdxMask) == '0;
`endif
   endfunction

   always_comb begin
      full          = (cnt_q == CntW'(SB_DEPTH));
      bus.req_ready = reset && (state_q == StRun) && !full;
      accept        = bus.req_valid && bus.req_ready;
      is_load       = accept && (bus.req_op == OpLoad);
      push          = accept && (bus.req_op == OpStore);
      drain         = reset && !is_load && (cnt_q != '0) &&
                      ((state_q == StDrain) || !bus.req_valid || full);

      // Walk oldest to youngest so the youngest matching entry wins.
      fwd_data = bus.dm_out;
      slot     = '0;
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
         slot = head_q + PtrW'(i);
         if ((CntW'(i) < cnt_q) && idx_hit(addr_q[slot], bus.req_addr)) begin
            fwd_data = data_q[slot];
         end
      end

      bus.dm_MemWr = drain;
      bus.dm_addr  = drain ? addr_q[head_q] : (is_load ? bus.req_addr : '0);
      bus.dm_in    = drain ? data_q[head_q] : '0;
`ifdef DM_LSU_MIRROR_EN
      bus.dm_MemWrComp = drain;
      bus.dm_addr_c    = drain ? (addr_q[head_q] ^ MirrorBit) : '0;
`else
      bus.dm_MemWrComp = 1'b0;
      bus.dm_addr_c    = '0;
`endif
      bus.rsp_valid = reset && rsp_valid_q;
      bus.rsp_rdata = rsp_rdata_q;
      bus.sb_count  = reset ? 3'(cnt_q) : 3'd0;
   end

   always_comb begin
      state_d     = state_q;
      head_d      = head_q;
      tail_d      = tail_q;
      addr_d      = addr_q;
      data_d      = data_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;

      if (push) begin
         addr_d[tail_q] = bus.req_addr;
         data_d[tail_q] = bus.req_wdata;
         tail_d         = tail_q + PtrW'(1);
      end
      if (drain) begin
         head_d = head_q + PtrW'(1);
      end
      cnt_d = cnt_q + CntW'(push) - CntW'(drain);

      if (is_load) begin
         rsp_valid_d = 1'b1;
         rsp_rdata_d = fwd_data;
      end else if (accept && (bus.req_op == OpFence)) begin
         if (cnt_q == '0) begin
            rsp_valid_d = 1'b1;
         end else begin
            state_d = StDrain;
         end
      end else if ((state_q == StDrain) && (cnt_q == '0)) begin
         rsp_valid_d = 1'b1;
         state_d     = StRun;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= StRun;
         cnt_q       <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Entry storage needs no reset: only slots counted by cnt_q are ever read.
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
   end
endmodule

// File: tb/tb_dm_lsu_initiator.sv
// Bench for dm_lsu_initiator: directed scenarios with literal expectations, then random traffic
// against a queue-based model of the store buffer and DM contents.
module tb_dm_lsu_initiator;
   localparam int unsigned Depth = 4;
   localparam logic [1:0] LD = 2'b00;
   localparam logic [1:0] ST = 2'b01;
   localparam logic [1:0] FN = 2'b10;
   localparam logic [1:0] RS = 2'b11;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dm_lsu_initiator_if bus ();

   dm_lsu_initiator #(
      .SB_DEPTH(Depth),
      .IDX_LSB (2),
      .IDX_W   (4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // DM array: combinational read, write captured on negedge.
   logic [31:0] dm_mem [16];
   assign bus.dm_out = dm_mem[bus.dm_addr[5:2]];

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } sb_ent_t;

   sb_ent_t     sb[$];
   logic [31:0] ref_mem [16];
   bit          m_fence;
   bit          m_rsp_v;
   logic [31:0] m_rsp_d;

   int n_checks = 0;
   int n_fail   = 0;

   logic        s_ready, s_memwr, s_comp, s_rspv;
   logic [31:0] s_addr, s_in, s_addr_c, s_rdata;
   logic [2:0]  s_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, want, $time);
      end
   endtask

   function automatic bit m_hit(logic [31:0] a, logic [31:0] b);
`ifdef DM_LSU_MIRROR_EN
      return (a[5:2] == b[5:2]) || (a[5:2] == (b[5:2] ^ 4'h8));
`else
      return a[5:2] == b[5:2];
`endif
   endfunction

   function automatic logic [31:0] m_load(logic [31:0] a);
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (m_hit(sb[i].addr, a)) return sb[i].data;
      end
      return ref_mem[a[5:2]];
   endfunction

   // One clock cycle: drive inputs, check every output against the model at negedge,
   // let DM capture, advance the model, land 1 time unit after the next posedge.
   task automatic cycle(input bit rst, input bit v, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] d);
      int          n;
      bit          e_ready, acc, ld, dr;
      sb_ent_t     h;
      logic [31:0] e_addr, e_in;
      reset         = rst;
      bus.req_valid = v;
      bus.req_op    = op;
      bus.req_addr  = a;
      bus.req_wdata = d;

      n       = sb.size();
      e_ready = rst && !m_fence && (n < Depth);
      acc     = v && e_ready;
      ld      = acc && (op == LD);
      dr      = rst && !ld && (n > 0) && (m_fence || !v || (n == Depth));
      h       = (n > 0) ? sb[0] : '0;
      e_addr  = dr ? h.addr : (ld ? a : 32'h0);
      e_in    = dr ? h.data : 32'h0;

      @(negedge clk);
      s_ready  = bus.req_ready;
      s_memwr  = bus.dm_MemWr;
      s_comp   = bus.dm_MemWrComp;
      s_addr   = bus.dm_addr;
      s_in     = bus.dm_in;
      s_addr_c = bus.dm_addr_c;
      s_rspv   = bus.rsp_valid;
      s_rdata  = bus.rsp_rdata;
      s_cnt    = bus.sb_count;

      chk("req_ready", 32'(s_ready), 32'(e_ready));
      chk("dm_MemWr", 32'(s_memwr), 32'(dr));
      chk("dm_addr", s_addr, e_addr);
      chk("dm_in", s_in, e_in);
`ifdef DM_LSU_MIRROR_EN
      chk("dm_MemWrComp", 32'(s_comp), 32'(dr));
      chk("dm_addr_c", s_addr_c, dr ? (h.addr ^ 32'h20) : 32'h0);
`else
      chk("dm_MemWrComp", 32'(s_comp), 32'h0);
      chk("dm_addr_c", s_addr_c, 32'h0);
`endif
      chk("rsp_valid", 32'(s_rspv), 32'(rst && m_rsp_v));
      chk("rsp_rdata", s_rdata, m_rsp_d);
      chk("sb_count", 32'(s_cnt), rst ? 32'(n) : 32'h0);

      if (bus.dm_MemWr) dm_mem[bus.dm_addr[5:2]] = bus.dm_in;
      if (bus.dm_MemWrComp) dm_mem[bus.dm_addr_c[5:2]] = bus.dm_in;

      if (!rst) begin
         sb.delete();
         m_fence = 1'b0;
         m_rsp_v = 1'b0;
         m_rsp_d = '0;
      end else begin
         m_rsp_v = 1'b0;
         m_rsp_d = '0;
         if (acc) begin
            case (op)
               ST: sb.push_back('{addr: a, data: d});
               LD: begin
                  m_rsp_v = 1'b1;
                  m_rsp_d = m_load(a);
               end
               FN: begin
                  if (n == 0) m_rsp_v = 1'b1;
                  else m_fence = 1'b1;
               end
               default: ;
            endcase
         end else if (m_fence && (n == 0)) begin
            m_rsp_v = 1'b1;
            m_fence = 1'b0;
         end
         if (dr) begin
            ref_mem[h.addr[5:2]] = h.data;
`ifdef DM_LSU_MIRROR_EN
            ref_mem[h.addr[5:2] ^ 4'h8] = h.data;
`endif
            void'(sb.pop_front());
         end
      end

      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cycle(1'b1, 1'b0, LD, 32'h0, 32'h0);
   endtask

   initial begin
      logic [31:0] fence_addrs [3];
      logic [31:0] a;
      logic [1:0]  op;
      int          r;
      for (int i = 0; i < 16; i++) begin
         dm_mem[i]  = $urandom;
         ref_mem[i] = dm_mem[i];
      end
      reset         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = LD;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      m_fence       = 1'b0;
      m_rsp_v       = 1'b0;
      m_rsp_d       = '0;
      @(posedge clk);
      #1;

      // Reset held with a pending request.
      for (int i = 0; i < 2; i++) begin
         cycle(1'b0, 1'b1, ST, 32'h08, 32'h1);
         chk("lit_rst_ready", 32'(s_ready), 32'h0);
         chk("lit_rst_memwr", 32'(s_memwr), 32'h0);
         chk("lit_rst_cnt", 32'(s_cnt), 32'h0);
         chk("lit_rst_rspv", 32'(s_rspv), 32'h0);
      end

      // Store, lazy drain on idle, load back.
      cycle(1'b1, 1'b1, ST, 32'h08, 32'hDEAD);
      idle(1);
      chk("lit_drain_memwr", 32'(s_memwr), 32'h1);
      chk("lit_drain_addr", s_addr, 32'h08);
      chk("lit_drain_in", s_in, 32'hDEAD);
      cycle(1'b1, 1'b1, LD, 32'h08, 32'h0);
      idle(1);
      chk("lit_load_rspv", 32'(s_rspv), 32'h1);
      chk("lit_load_rdata", s_rdata, 32'hDEAD);

      // Youngest buffered store forwards; load cycle never drains.
      cycle(1'b1, 1'b1, ST, 32'h10, 32'h11);
      cycle(1'b1, 1'b1, ST, 32'h10, 32'h22);
      cycle(1'b1, 1'b1, LD, 32'h10, 32'h0);
      chk("lit_fwd_nodrain", 32'(s_memwr), 32'h0);
      idle(1);
      chk("lit_fwd_rdata", s_rdata, 32'h22);
      idle(3);

      // Aliased address forwards from the buffer.
      cycle(1'b1, 1'b1, ST, 32'h44, 32'h77);
      cycle(1'b1, 1'b1, LD, 32'h04, 32'h0);
      idle(1);
      chk("lit_alias_rdata", s_rdata, 32'h77);
      idle(2);

      // Five back-to-back stores against a four-entry buffer.
      for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, ST, 32'h20 + 32'(4 * k), 32'(k));
      cycle(1'b1, 1'b1, ST, 32'h30, 32'h5);
      chk("lit_full_cnt", 32'(s_cnt), 32'h4);
      chk("lit_full_ready", 32'(s_ready), 32'h0);
      chk("lit_full_memwr", 32'(s_memwr), 32'h1);
      chk("lit_full_addr", s_addr, 32'h20);
      cycle(1'b1, 1'b1, ST, 32'h30, 32'h5);
      chk("lit_full_retry", 32'(s_ready), 32'h1);
      idle(6);

      // Fence drains three stores in order, then responds.
      fence_addrs[0] = 32'h00;
      fence_addrs[1] = 32'h04;
      fence_addrs[2] = 32'h0C;
      for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, ST, fence_addrs[k], 32'hA0 + 32'(k));
      cycle(1'b1, 1'b1, FN, 32'h0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         idle(1);
         chk("lit_fence_ready", 32'(s_ready), 32'h0);
         chk("lit_fence_memwr", 32'(s_memwr), 32'h1);
         chk("lit_fence_addr", s_addr, fence_addrs[k]);
      end
      idle(1);
      chk("lit_fence_cnt", 32'(s_cnt), 32'h0);
      idle(1);
      chk("lit_fence_rspv", 32'(s_rspv), 32'h1);
      chk("lit_fence_rdata", s_rdata, 32'h0);

      // Fence on an empty buffer responds next cycle.
      cycle(1'b1, 1'b1, FN, 32'h0, 32'h0);
      idle(1);
      chk("lit_efence_rspv", 32'(s_rspv), 32'h1);

      // Reset discards buffered stores.
      cycle(1'b1, 1'b1, ST, 32'h14, 32'h1);
      cycle(1'b1, 1'b1, ST, 32'h18, 32'h2);
      cycle(1'b0, 1'b0, LD, 32'h0, 32'h0);
      for (int k = 0; k < 2; k++) begin
         idle(1);
         chk("lit_discard_cnt", 32'(s_cnt), 32'h0);
         chk("lit_discard_memwr", 32'(s_memwr), 32'h0);
      end

      // Mirror port on drain.
      cycle(1'b1, 1'b1, ST, 32'h04, 32'h5);
      idle(1);
      chk("lit_mir_memwr", 32'(s_memwr), 32'h1);
`ifdef DM_LSU_MIRROR_EN
      chk("lit_mir_comp", 32'(s_comp), 32'h1);
      chk("lit_mir_addr_c", s_addr_c, 32'h24);
`else
      chk("lit_mir_comp", 32'(s_comp), 32'h0);
      chk("lit_mir_addr_c", s_addr_c, 32'h0);
`endif

      // Random traffic.
      for (int c = 0; c < 4000; c++) begin
         r  = $urandom_range(0, 9);
         op = (r < 4) ? ST : (r < 7) ? LD : (r < 9) ? FN : RS;
         a  = 32'($urandom_range(0, 15)) << 2;
         a  = a | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FFC0);
         cycle($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7, op, a, $urandom);
      end
      idle(8);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
